multicycle_control: RTL

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Decodes the same instruction subset.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with instruction and data memories that take a variable number of cycles.
- Registers all datapath control fields, flags illegal encodings and memory timeouts, and sits between the IR/datapath and the memory ports.

---
 rtl/multicycle_control.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// variable-latency instruction/data memory handshakes, registers decoded
// datapath fields, and traps on illegal encodings or memory timeouts.
// Optional performance counters are enabled by MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control #(
  parameter int unsigned ALUOP_W     = 6,
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [ALUOP_W-1:0] func_in,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUsrc,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         Jump,
  output logic [1:0]         Size_in,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               timeout
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Completion path of an instruction after EXEC.
  typedef enum logic [1:0] {
    C_PCONLY = 2'd0,
    C_WB     = 2'd1,
    C_LOAD   = 2'd2,
    C_STORE  = 2'd3
  } iclass_t;

  state_t            cur, nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              set_illegal, set_timeout;
  logic              imem_req_c, irwrite_c, pcwrite_c, regwrite_c, memread_c, memwrite_c;

  // Decoder outputs (combinational) and their registered copies
  logic              dec_legal;
  logic [5:0]        dec_func6;
  logic [1:0]        dec_regdst, dec_alusrc, dec_memtoreg, dec_jump, dec_size;
  iclass_t           dec_cls;
  logic [ALUOP_W+5:0] func_ext;

  logic [ALUOP_W-1:0] func_q;
  logic [1:0]        regdst_q, alusrc_q, memtoreg_q, jump_q, size_q;
  iclass_t           cls_q;

  // Instruction decode of opCode/funct/rt into datapath fields and class
  always_comb begin
    dec_legal    = 1'b1;
    dec_func6    = '0;
    dec_regdst   = 2'b00;
    dec_alusrc   = 2'b00;
    dec_memtoreg = 2'b00;
    dec_jump     = 2'b00;
    dec_size     = 2'b00;
    dec_cls      = C_PCONLY;
    case (opCode)
      6'h00: begin
        case (funct)
          6'h00: dec_func6 = 6'b000000;
          6'h08: begin
            dec_func6 = 6'b111010;
            dec_jump  = 2'b10;
          end
          6'h09: begin
            dec_func6    = 6'b111010;
            dec_regdst   = 2'b01;
            dec_memtoreg = 2'b10;
            dec_jump     = 2'b10;
            dec_cls      = C_WB;
          end
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            dec_func6  = funct;
            dec_regdst = 2'b01;
            dec_size   = 2'b11;
            dec_cls    = C_WB;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0)      dec_func6 = 6'b111000;
        else if (rt == 5'd1) dec_func6 = 6'b111001;
        else                 dec_legal = 1'b0;
      end
      6'h02: begin
        dec_func6 = 6'b111010;
        dec_jump  = 2'b01;
      end
      6'h03: begin
        dec_func6    = 6'b111010;
        dec_regdst   = 2'b10;
        dec_memtoreg = 2'b10;
        dec_jump     = 2'b01;
        dec_cls      = C_WB;
      end
      6'h04, 6'h05, 6'h06, 6'h07: dec_func6 = {4'b1111, opCode[1:0]};
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
        dec_func6  = {2'b10, opCode[3:0]};
        dec_alusrc = 2'b01;
        dec_size   = 2'b11;
        dec_cls    = C_WB;
      end
      6'h0F: begin
        dec_func6  = 6'b100000;
        dec_alusrc = 2'b10;
        dec_size   = 2'b11;
        dec_cls    = C_WB;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_func6    = 6'b100000;
        dec_alusrc   = 2'b01;
        dec_memtoreg = 2'b01;
        dec_size     = (opCode[1:0] == 2'b11) ? 2'b11 : {1'b0, opCode[0]};
        dec_cls      = C_LOAD;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec_func6  = 6'b100000;
        dec_alusrc = 2'b01;
        dec_size   = (opCode[1:0] == 2'b11) ? 2'b11 : {1'b0, opCode[0]};
        dec_cls    = C_STORE;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Zero-extend then truncate the 6-bit encoding to the ALU op width
  assign func_ext = {{ALUOP_W{1'b0}}, dec_func6};

  // Decoded field registers, loaded only by a legal DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      func_q     <= '0;
      regdst_q   <= '0;
      alusrc_q   <= '0;
      memtoreg_q <= '0;
      jump_q     <= '0;
      size_q     <= '0;
      cls_q      <= C_PCONLY;
    end else if (cur == S_DECODE && dec_legal) begin
      func_q     <= func_ext[ALUOP_W-1:0];
      regdst_q   <= dec_regdst;
      alusrc_q   <= dec_alusrc;
      memtoreg_q <= dec_memtoreg;
      jump_q     <= dec_jump;
      size_q     <= dec_size;
      cls_q      <= dec_cls;
    end
  end

  // State, wait counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  // Next-state and strobe generation; strobes forced low while reset is held
  always_comb begin
    nxt          = cur;
    wait_cnt_nxt = '0;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;
    imem_req_c   = 1'b0;
    irwrite_c    = 1'b0;
    pcwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    memread_c    = 1'b0;
    memwrite_c   = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          irwrite_c = 1'b1;
          nxt       = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          nxt         = S_TRAP;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          nxt = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          nxt         = S_TRAP;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_PCONLY: begin
            pcwrite_c = 1'b1;
            nxt       = S_FETCH;
          end
          C_WB:    nxt = S_WB;
          default: nxt = S_MEM;
        endcase
      end
      S_MEM: begin
        memread_c  = (cls_q == C_LOAD);
        memwrite_c = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pcwrite_c = 1'b1;
            nxt       = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          nxt         = S_TRAP;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_WB: begin
        regwrite_c = 1'b1;
        pcwrite_c  = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
    if (reset) begin
      imem_req_c = 1'b0;
      irwrite_c  = 1'b0;
      pcwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
    end
  end

  assign imem_req = imem_req_c;
  assign IRWrite  = irwrite_c;
  assign PCWrite  = pcwrite_c;
  assign RegWrite = regwrite_c;
  assign MemRead  = memread_c;
  assign MemWrite = memwrite_c;
  assign func_in  = func_q;
  assign RegDst   = regdst_q;
  assign ALUsrc   = alusrc_q;
  assign MemtoReg = memtoreg_q;
  assign Jump     = jump_q;
  assign Size_in  = size_q;
  assign state    = cur;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  // Cycle and retired-instruction counters, frozen while trapped
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else if (cur != S_TRAP) begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (pcwrite_c) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule
